// File: rtl/stream_conv_pkg.sv
// Shared definitions for the stream_conv3x3 pixel pipeline: mode encodings,
// accumulator width derivation and unsigned output saturation.
package stream_conv_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_INV  = 2'b01;
    localparam logic [1:0] MODE_CONV = 2'b10;
    localparam logic [1:0] MODE_THR  = 2'b11;

    // Nine products of a zero-extended pixel and a signed coefficient, plus sign headroom.
    function automatic int acc_width(input int data_w, input int coef_w);
        acc_width = data_w + coef_w + 5;
    endfunction

    // Clamp a signed value into the unsigned range [0, 2^w-1].
    function automatic logic [63:0] sat_unsigned(input logic signed [63:0] v, input int w);
        logic signed [63:0] max_v;
        max_v = (64'sd1 <<< w) - 64'sd1;
        if (v < 64'sd0) begin
            sat_unsigned = 64'd0;
        end else if (v > max_v) begin
            sat_unsigned = $unsigned(max_v);
        end else begin
            sat_unsigned = $unsigned(v);
        end
    endfunction

endpackage

// File: rtl/conv_window3x3.sv
// Two raster line buffers, a 3x3 sliding window and the col/row frame position.
// The exported taps are the window as it will look after the current accept.
module conv_window3x3
    import stream_conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  accept,
    input  logic [DATA_W-1:0]     in_data,
    output logic [9*DATA_W-1:0]   taps,
    output logic                  interior,
    output logic                  first,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] lb2_q [IMG_W];
    logic [DATA_W-1:0] win_q [3][3];
    logic [DATA_W-1:0] win_d [3][3];
    logic [DATA_W-1:0] new_col_s [3];
    logic              last_col_s, last_row_s;

    // Incoming column: oldest line on top, live pixel at the bottom.
    always_comb begin
        new_col_s[0] = lb2_q[col_q];
        new_col_s[1] = lb1_q[col_q];
        new_col_s[2] = in_data;
    end

    // Position counters, frame-done pulse and window shift.
    always_comb begin
        last_col_s   = (col_q == COL_W'(IMG_W - 1));
        last_row_s   = (row_q == ROW_W'(IMG_H - 1));
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        win_d        = win_q;
        if (accept) begin
            if (last_col_s) begin
                col_d = {COL_W{1'b0}};
                if (last_row_s) begin
                    row_d = {ROW_W{1'b0}};
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
                row_d = row_q;
            end
            frame_done_d = last_col_s && last_row_s;
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
                win_d[r][2] = new_col_s[r];
            end
        end else begin
            frame_done_d = 1'b0;
        end
        busy_d = (col_d != {COL_W{1'b0}}) || (row_d != {ROW_W{1'b0}});
    end

    // Taps in k-index order: i = 3*r + c, c0 oldest column.
    always_comb begin
        taps = {(9*DATA_W){1'b0}};
        for (int r = 0; r < 3; r++) begin
            taps[(3*r+0)*DATA_W +: DATA_W] = win_q[r][1];
            taps[(3*r+1)*DATA_W +: DATA_W] = win_q[r][2];
            taps[(3*r+2)*DATA_W +: DATA_W] = new_col_s[r];
        end
    end

    assign interior = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    assign first    = (row_q == {ROW_W{1'b0}}) && (col_q == {COL_W{1'b0}});
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

    // Control state and window registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            col_q        <= {COL_W{1'b0}};
            row_q        <= {ROW_W{1'b0}};
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= {DATA_W{1'b0}};
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            win_q        <= win_d;
        end
    end

    // Line buffers keep their contents through reset; rows 0-1 are never emitted anyway.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= in_data;
            lb2_q[col_q] <= lb1_q[col_q];
        end
    end

endmodule

// File: rtl/stream_conv3x3.sv
// Streaming 3x3 pixel processor: pass, invert or signed-kernel convolution with
// shift and saturation. Optional threshold mode under STREAM_CONV_THRESH_EN.
module stream_conv3x3
    import stream_conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic [1:0]           mode,
    input  logic [9*COEF_W-1:0]  kernel,
    input  logic [3:0]           shift,
    input  logic [DATA_W-1:0]    thresh,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W);

    logic                     accept_s;
    logic [9*DATA_W-1:0]      taps_s;
    logic                     interior_s, first_s;
    logic [1:0]               mode_q, mode_d, mode_eff_s;
    logic signed [ACC_W-1:0]  pix_ext_s, coef_ext_s, acc_s, shifted_s;
    logic signed [63:0]       wide_s;
    logic [DATA_W-1:0]        conv_pix_s, result_s;
    logic                     produce_s;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    conv_window3x3 #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) u_window (
        .clk        (clk),
        .rstn       (rstn),
        .accept     (accept_s),
        .in_data    (in_data),
        .taps       (taps_s),
        .interior   (interior_s),
        .first      (first_s),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // Mode is captured with pixel (0,0); that pixel already uses the live value.
    always_comb begin
        if (first_s) begin
            mode_eff_s = mode;
        end else begin
            mode_eff_s = mode_q;
        end
        if (accept_s && first_s) begin
            mode_d = mode;
        end else begin
            mode_d = mode_q;
        end
    end

    // Signed multiply-accumulate over the window, then shift and clamp.
    always_comb begin
        acc_s      = {ACC_W{1'b0}};
        pix_ext_s  = {ACC_W{1'b0}};
        coef_ext_s = {ACC_W{1'b0}};
        for (int i = 0; i < 9; i++) begin
            pix_ext_s                = {ACC_W{1'b0}};
            pix_ext_s[DATA_W-1:0]    = taps_s[i*DATA_W +: DATA_W];
            coef_ext_s = {{(ACC_W-COEF_W){kernel[i*COEF_W + COEF_W - 1]}},
                          kernel[i*COEF_W +: COEF_W]};
            acc_s = acc_s + pix_ext_s * coef_ext_s;
        end
        shifted_s  = acc_s >>> shift;
        wide_s     = {{(64-ACC_W){shifted_s[ACC_W-1]}}, shifted_s};
        conv_pix_s = DATA_W'(sat_unsigned(wide_s, DATA_W));
    end

`ifdef STREAM_CONV_THRESH_EN
    logic [DATA_W-1:0] thr_pix_s;
    always_comb begin
        if (in_data >= thresh) begin
            thr_pix_s = {DATA_W{1'b1}};
        end else begin
            thr_pix_s = {DATA_W{1'b0}};
        end
    end
`else
    logic unused_thresh_s;
    assign unused_thresh_s = ^thresh;
`endif

    // Output value select and whether this accept emits anything.
    always_comb begin
        produce_s = 1'b1;
        case (mode_eff_s)
            MODE_PASS: result_s = in_data;
            MODE_INV:  result_s = ~in_data;
            MODE_CONV: begin
                result_s  = conv_pix_s;
                produce_s = interior_s;
            end
`ifdef STREAM_CONV_THRESH_EN
            MODE_THR:  result_s = thr_pix_s;
`else
            MODE_THR:  result_s = in_data;
`endif
            default:   result_s = in_data;
        endcase
    end

    // Single output register; an unaccepted output is held until taken.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept_s) begin
            if (produce_s) begin
                out_valid_d = 1'b1;
                out_data_d  = result_s;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output and mode state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
            mode_q      <= MODE_PASS;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            mode_q      <= mode_d;
        end
    end

endmodule
